// File: rtl/cardjitsu_pkg.sv
// Shared definitions for the Card-Jitsu game and its scripted auto dealer.
// Holds the dealer state encoding, deck sizes and the LFSR-to-card mapping.
package cardjitsu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        PRESS = 2'd2,
        GAP   = 2'd3
    } dealer_state_t;

    localparam int         CARD_SLOTS = 6;
    localparam int         DECK_TOTAL = 12;
    localparam logic [3:0] NULL_CARD  = 4'h0;

    // The game reads a zero card as an empty slot, so zero is remapped to one.
    function automatic logic [3:0] card_from_lfsr(input logic [7:0] state);
        logic [3:0] card;
        card = state[3:0];
        if (card == NULL_CARD) begin
            card = 4'h1;
        end
        return card;
    endfunction

endpackage

// File: rtl/cardjitsu_lfsr8.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4) that shifts left with feedback into bit 0.
// It advances only when i_step is high.
module cardjitsu_lfsr8 (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_step,
    input  logic [7:0] i_seed,
    output logic [7:0] o_state
);

    logic [7:0] r_state;
    logic       w_feedback;

    assign w_feedback = r_state[7] ^ r_state[5] ^ r_state[4] ^ r_state[3];
    assign o_state    = r_state;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= i_seed;
        end else if (i_step) begin
            r_state <= {r_state[6:0], w_feedback};
        end
    end

endmodule

// File: rtl/cardjitsu_auto_dealer.sv
// Scripted player for the Card-Jitsu input port: it turns deal and slot-play
// commands into press sequences on sw/btn that the game can sample.
module cardjitsu_auto_dealer
    import cardjitsu_pkg::*;
#(
    parameter int unsigned PRESS_CYCLES = 4,
    parameter int unsigned GAP_CYCLES   = 4,
    parameter logic [7:0]  LFSR_SEED    = 8'hA5
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic       i_play_valid,
    input  logic [2:0] i_play_slot,
    output logic       o_play_ready,
    output logic [3:0] o_sw_out,
    output logic       o_btn_out,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_slot_err,
    output logic [3:0] o_deal_idx
);

    localparam int         CNT_MAX = (PRESS_CYCLES > GAP_CYCLES) ? int'(PRESS_CYCLES) : int'(GAP_CYCLES);
    localparam int         CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [7:0] SEED    = (LFSR_SEED == 8'h00) ? 8'hA5 : LFSR_SEED;

    dealer_state_t    r_state;
    logic             r_deal_mode;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_sw;
    logic             r_btn;
    logic             r_done;
    logic             r_slot_err;
    logic [3:0]       r_deal_idx;

    logic [7:0]       w_lfsr;
    logic             w_lfsr_step;
    logic             w_slot_ok;

    // The LFSR advances during SETUP, after that card has already been latched.
    assign w_lfsr_step = (r_state == SETUP) && r_deal_mode;
    assign w_slot_ok   = (i_play_slot != 3'd0) && (i_play_slot <= 3'(CARD_SLOTS));

    cardjitsu_lfsr8 u_lfsr (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_step  (w_lfsr_step),
        .i_seed  (SEED),
        .o_state (w_lfsr)
    );

    assign o_play_ready = (r_state == IDLE) && !i_start && !i_rst;
    assign o_sw_out     = r_sw;
    assign o_btn_out    = r_btn;
    assign o_busy       = (r_state != IDLE);
    assign o_done       = r_done;
    assign o_slot_err   = r_slot_err;
    assign o_deal_idx   = r_deal_idx;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_deal_mode <= 1'b0;
            r_cnt       <= '0;
            r_sw        <= 4'h0;
            r_btn       <= 1'b0;
            r_done      <= 1'b0;
            r_slot_err  <= 1'b0;
            r_deal_idx  <= 4'd0;
        end else begin
            r_done     <= 1'b0;
            r_slot_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_state     <= SETUP;
                        r_deal_mode <= 1'b1;
                        r_deal_idx  <= 4'd0;
                        r_sw        <= card_from_lfsr(w_lfsr);
                    end else if (i_play_valid) begin
                        // Illegal slots are consumed so the host is not stalled forever.
                        if (w_slot_ok) begin
                            r_state     <= SETUP;
                            r_deal_mode <= 1'b0;
                            r_sw        <= {1'b0, i_play_slot};
                        end else begin
                            r_slot_err <= 1'b1;
                        end
                    end
                end
                SETUP: begin
                    r_state <= PRESS;
                    r_btn   <= 1'b1;
                    r_cnt   <= CNT_W'(PRESS_CYCLES - 1);
                end
                PRESS: begin
                    if (r_cnt == '0) begin
                        r_state <= GAP;
                        r_btn   <= 1'b0;
                        r_cnt   <= CNT_W'(GAP_CYCLES - 1);
                        if (r_deal_mode) begin
                            r_deal_idx <= r_deal_idx + 4'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                GAP: begin
                    if (r_cnt == '0) begin
                        if (r_deal_mode && (r_deal_idx < 4'(DECK_TOTAL))) begin
                            r_state <= SETUP;
                            r_sw    <= card_from_lfsr(w_lfsr);
                        end else begin
                            r_state <= IDLE;
                            r_done  <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
